// File: rtl/dmem_bank_ctrl.sv
// Byte-lane data memory with sized/sign-extended loads, registered read data and a wait-state handshake.
// Optional misalignment checking is compiled in with `define DMEM_MISALIGN_CHK_EN.
module dmem_bank_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic              WE,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic              i_m_readdata_valid,
    output logic              i_m_waitrequest,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic             valid_reg;
    logic [2:0]       f3_reg;
    logic [1:0]       off_reg;
    logic             misal_rd_reg;

    logic             req;
    logic             complete;
    logic             do_write;
    logic             do_read;
    logic             misaligned;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [7:0]       rd_b;
    logic [15:0]      rd_h;
    logic             unused_addr;

    assign req         = ren | WE;
    assign idx         = A[IDX_W+1:2];
    assign unused_addr = ^A;

    // Completion is the edge that ends the cycle in which waitrequest is low for an accepted access.
    always_comb begin
        complete        = 1'b0;
        i_m_waitrequest = 1'b0;
        if (rst) begin
            if (state_reg == ST_IDLE) begin
                if (WAIT_STATES == 0) complete = req;
                else                  i_m_waitrequest = req;
            end else begin
                if (cnt_reg == 4'd0) complete = 1'b1;
                else                 i_m_waitrequest = 1'b1;
            end
        end
    end

    assign do_write = complete & WE;
    assign do_read  = complete & ren & ~WE;

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = WD;
        if (funct3 == 3'b000) begin
            wr_be   = 4'b0001 << A[1:0];
            wr_data = {4{WD[7:0]}};
        end else if (funct3 == 3'b001) begin
            wr_be   = A[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{WD[15:0]}};
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic [1:0] size_code;
    logic       err_reg;

    // Stores and loads decode reserved encodings differently: 101 is LHU for loads but a word store.
    always_comb begin
        if (WE) size_code = (funct3 == 3'b000) ? 2'd0 : (funct3 == 3'b001) ? 2'd1 : 2'd2;
        else    size_code = (funct3[1:0] == 2'b00) ? 2'd0 : (funct3[1:0] == 2'b01) ? 2'd1 : 2'd2;
    end

    assign misaligned = ((size_code == 2'd1) && A[0]) ||
                        ((size_code == 2'd2) && (A[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!rst) err_reg <= 1'b0;
        else      err_reg <= (do_read | do_write) & misaligned;
    end

    assign err = err_reg;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    // One RAM per byte lane so each lane has its own write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (do_write && wr_be[gi] && !misaligned) mem[idx] <= wr_data[gi*8 +: 8];
                if (do_read) rd_byte_reg <= mem[idx];
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            valid_reg    <= 1'b0;
            misal_rd_reg <= 1'b0;
        end else begin
            valid_reg <= do_read;
            if (do_read) begin
                f3_reg       <= funct3;
                off_reg      <= A[1:0];
                misal_rd_reg <= misaligned;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (req && (WAIT_STATES != 0)) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) state_reg <= ST_IDLE;
                    else                 cnt_reg   <= cnt_reg - 4'd1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rd_b = rd_word[{off_reg, 3'b000} +: 8];
    assign rd_h = rd_word[{off_reg[1], 4'b0000} +: 16];

    always_comb begin
        RD = 32'd0;
        if (valid_reg && !misal_rd_reg) begin
            case (f3_reg[1:0])
                2'b00:   RD = f3_reg[2] ? {24'd0, rd_b} : {{24{rd_b[7]}}, rd_b};
                2'b01:   RD = f3_reg[2] ? {16'd0, rd_h} : {{16{rd_h[15]}}, rd_h};
                default: RD = rd_word;
            endcase
        end
    end

    assign i_m_readdata_valid = valid_reg;
endmodule

// File: tb/tb_dmem_bank_ctrl.sv
// Bench for dmem_bank_ctrl: a zero-wait and a three-wait instance checked against a byte-array model.
module tb_dmem_bank_ctrl;
    localparam int DEPTH = 1024;
    localparam int MB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ren0 = 1'b0, we0 = 1'b0;
    logic [2:0]  f3_0 = 3'd0;
    logic [31:0] a0 = 32'd0, wd0 = 32'd0, rd0;
    logic        v0, wr0, e0;

    logic        ren3 = 1'b0, we3 = 1'b0;
    logic [2:0]  f3_3 = 3'd0;
    logic [31:0] a3 = 32'd0, wd3 = 32'd0, rd3;
    logic        v3, wr3, e3;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] mdl [2][MB];

    always #5 clk = ~clk;

    dmem_bank_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) u_ws0 (
        .clk(clk), .rst(rst), .ren(ren0), .WE(we0), .funct3(f3_0), .A(a0), .WD(wd0),
        .RD(rd0), .i_m_readdata_valid(v0), .i_m_waitrequest(wr0), .err(e0)
    );

    dmem_bank_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .ADDR_W(32)) u_ws3 (
        .clk(clk), .rst(rst), .ren(ren3), .WE(we3), .funct3(f3_3), .A(a3), .WD(wd3),
        .RD(rd3), .i_m_readdata_valid(v3), .i_m_waitrequest(wr3), .err(e3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Access size in bytes; loads decode on funct3[1:0], stores on the whole field.
    function automatic int acc_size(input bit is_wr, input logic [2:0] f3);
        if (is_wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit mdl_misal(input bit is_wr, input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
        return (int'(a[1:0]) % acc_size(is_wr, f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic mdl_write(input int s, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz;
        int base;
        sz = acc_size(1'b1, f3);
        if (mdl_misal(1'b1, f3, a)) return;
        base = (int'(a[11:0]) / sz) * sz;
        for (int i = 0; i < sz; i++) mdl[s][base + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] mdl_read(input int s, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int base;
        logic [31:0] v;
        v  = 32'd0;
        sz = acc_size(1'b0, f3);
        if (mdl_misal(1'b0, f3, a)) return 32'd0;
        base = (int'(a[11:0]) / sz) * sz;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mdl[s][base + i];
        if (sz < 4 && !f3[2] && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic acc3(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop, input logic ev,
                        input logic [31:0] erd, input logic ee, input string nm);
        int k;
        k = 0;
        @(negedge clk);
        ren3 = r; we3 = w; f3_3 = f3; a3 = a; wd3 = wd;
        #1;
        while (wr3 === 1'b1 && k < 20) begin
            chk({nm, "_valid_in_wait"}, 32'(v3), 32'd0);
            k++;
            @(negedge clk);
            if (drop) begin
                ren3 = 1'b0;
                we3  = 1'b0;
            end
            #1;
        end
        chk({nm, "_waits"}, k, 32'd3);
        chk({nm, "_valid_at_done"}, 32'(v3), 32'd0);
        @(negedge clk);
        ren3 = 1'b0; we3 = 1'b0;
        #1;
        chk({nm, "_valid"}, 32'(v3), 32'(ev));
        chk({nm, "_rd"}, rd3, erd);
        chk({nm, "_err"}, 32'(e3), 32'(ee));
        $display("ws3 %s ren=%0b we=%0b f3=%0d a=%h wd=%h waits=%0d valid=%0b rd=%h err=%0b",
                 nm, r, w, f3, a, wd, k, v3, rd3, e3);
    endtask

    typedef struct {
        logic        ren;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] erd;
        logic        ee;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        ev, ee;
        logic [31:0] erd, tmp, a;
        logic [2:0]  f3;
        logic        r, w;
        int          op;

        tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0002, 32'hFFFF_FFAA, 1'b0, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b1, 32'h11AA_3344, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0,         1'b1, 32'hFFFF_FFAA, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0002, 32'h0,         1'b1, 32'h0000_00AA, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,         1'b1, 32'h0000_11AA, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_3344, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'hFFFF_1234, 1'b0, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0,         1'b1, 32'h1234_F00D, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0007, 1'b0, 32'h0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0007, 1'b0};
`ifdef DMEM_MISALIGN_CHK_EN
        tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0,         1'b1, 32'h0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 1'b0, 32'h0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0007, 1'b0};
`else
        tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0,         1'b1, 32'h0000_0007, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_BEEF, 1'b0};
`endif
        tbl[17] = '{1'b1, 1'b0, 3'b001, 32'h0000_0004, 32'h0,         1'b1, 32'hFFFF_F00D, 1'b0};

        // Reset: outputs clear and a request is ignored while reset is held.
        repeat (3) @(negedge clk);
        ren3 = 1'b1;
        #1;
        chk("rst_wr3_gated", 32'(wr3), 32'd0);
        chk("rst_v0", 32'(v0), 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_e0", 32'(e0), 32'd0);
        chk("rst_v3", 32'(v3), 32'd0);
        chk("rst_rd3", rd3, 32'd0);
        @(negedge clk);
        ren3 = 1'b0;
        rst  = 1'b1;

        // Directed vectors, back to back at one request per cycle on the zero-wait instance.
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("tbl%0d_valid", i-1), 32'(v0), 32'(tbl[i-1].ev));
                chk($sformatf("tbl%0d_rd", i-1), rd0, tbl[i-1].erd);
                chk($sformatf("tbl%0d_err", i-1), 32'(e0), 32'(tbl[i-1].ee));
                $display("ws0 tbl%0d ren=%0b we=%0b f3=%0d a=%h wd=%h valid=%0b rd=%h err=%0b",
                         i-1, tbl[i-1].ren, tbl[i-1].we, tbl[i-1].f3, tbl[i-1].a, tbl[i-1].wd, v0, rd0, e0);
            end
            if (i < NV) begin
                ren0 = tbl[i].ren; we0 = tbl[i].we; f3_0 = tbl[i].f3; a0 = tbl[i].a; wd0 = tbl[i].wd;
            end else begin
                ren0 = 1'b0; we0 = 1'b0;
            end
            #1;
            chk("ws0_waitreq", 32'(wr0), 32'd0);
        end

        // Randomised stream on the zero-wait instance; the first 16 requests fill the address window.
        ev = 1'b0; erd = 32'd0; ee = 1'b0;
        for (int n = 0; n < 216; n++) begin
            @(negedge clk);
            chk("ws0_rnd_valid", 32'(v0), 32'(ev));
            chk("ws0_rnd_rd", rd0, erd);
            chk("ws0_rnd_err", 32'(e0), 32'(ee));
            tmp = $urandom();
            if (n < 16) begin
                op = 1; f3 = 3'b010; a = {tmp[31:12], 6'd0, 6'(n * 4)};
            end else begin
                op = $urandom_range(0, 4); f3 = 3'($urandom_range(0, 7));
                a  = {tmp[31:12], 6'd0, 6'($urandom_range(0, 63))};
            end
            r = (op >= 2); w = (op == 1) || (op == 4);
            ren0 = r; we0 = w; f3_0 = f3; a0 = a; wd0 = $urandom();
            if (w) begin
                ev = 1'b0; erd = 32'd0; ee = mdl_misal(1'b1, f3, a);
                mdl_write(0, f3, a, wd0);
            end else if (r) begin
                ev = 1'b1; erd = mdl_read(0, f3, a); ee = mdl_misal(1'b0, f3, a);
            end else begin
                ev = 1'b0; erd = 32'd0; ee = 1'b0;
            end
            $display("ws0 rnd%0d ren=%0b we=%0b f3=%0d a=%h wd=%h", n, r, w, f3, a, wd0);
            #1;
            chk("ws0_rnd_waitreq", 32'(wr0), 32'd0);
        end
        @(negedge clk);
        ren0 = 1'b0; we0 = 1'b0;
        chk("ws0_rnd_last_valid", 32'(v0), 32'(ev));
        chk("ws0_rnd_last_rd", rd0, erd);

        // Three-wait instance: timing, dropped requests and reset during WAIT.
        acc3(1'b0, 1'b1, 3'b010, 32'h20, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, "sw20");
        acc3(1'b0, 1'b1, 3'b010, 32'h24, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0, "sw24");
        acc3(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, "lw20");
        acc3(1'b0, 1'b1, 3'b010, 32'h24, 32'h99, 1'b1, 1'b0, 32'h0, 1'b0, "drop_wr");
        acc3(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, "drop_rd");
        acc3(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, "lw24");

        @(negedge clk);
        we3 = 1'b1; f3_3 = 3'b010; a3 = 32'h20; wd3 = 32'h5;
        #1;
        chk("rstw_t0_waitreq", 32'(wr3), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_waitreq_in_rst", 32'(wr3), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rstw_valid", 32'(v3), 32'd0);
            chk("rstw_rd", rd3, 32'd0);
            chk("rstw_err", 32'(e3), 32'd0);
            chk("rstw_waitreq", 32'(wr3), 32'd0);
        end
        rst = 1'b1; we3 = 1'b0;
        $display("ws3 reset during WAIT of sw20 wd=00000005");
        acc3(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, "lw20_after_rst");

        for (int n = 0; n < 16; n++) begin
            tmp = $urandom();
            a   = {tmp[31:12], 6'd0, 6'(n * 4)};
            wd3 = $urandom();
            mdl_write(1, 3'b010, a, wd3);
            acc3(1'b0, 1'b1, 3'b010, a, wd3, 1'b0, 1'b0, 32'h0, 1'b0, "init");
        end
        for (int n = 0; n < 40; n++) begin
            tmp = $urandom();
            op  = $urandom_range(0, 3);
            f3  = 3'($urandom_range(0, 7));
            a   = {tmp[31:12], 6'd0, 6'($urandom_range(0, 63))};
            tmp = $urandom();
            r = (op != 0); w = (op == 0) || (op == 3);
            if (w) begin
                ee = mdl_misal(1'b1, f3, a);
                mdl_write(1, f3, a, tmp);
                acc3(r, w, f3, a, tmp, 1'b0, 1'b0, 32'h0, ee, "rnd_wr");
            end else begin
                acc3(r, w, f3, a, tmp, 1'b0, 1'b1, mdl_read(1, f3, a), mdl_misal(1'b0, f3, a), "rnd_rd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
